// File: rtl/seven_seg_display_driver.sv
// seven_seg_display_driver
//
// Time-multiplexes an 8-bit value onto a four-digit common-anode
// seven-segment display. Each digit is lit for REFRESH_DIV clock cycles in
// turn (digit 0 is the rightmost). All outputs are registered.
//
// Optional feature macro: SEVENSEG_DECIMAL_EN
//   undefined : hex display, digit0 = low nibble, digit1 = high nibble,
//               digits 2/3 blank, BUSY_OUT tied low.
//   defined   : a sequential double-dabble converter turns the value into
//               ones/tens/hundreds with leading-zero blanking; digit3 blank.
//
// Ports
//   CLK            in   system clock, rising edge
//   RESET          in   synchronous, active-low reset
//   DATA_IN[7:0]   in   value to display
//   DOT_IN[3:0]    in   decimal-point request per digit, active-high
//   SEG_SELECT_OUT out  digit anode enables, active-low, bit0 = rightmost
//   HEX_OUT[7:0]   out  segment cathodes, active-low, {DP,G,F,E,D,C,B,A}
//   BUSY_OUT       out  converter running (decimal mode only)
module seven_seg_display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DATA_IN,
  input  logic [3:0] DOT_IN,
  output logic [3:0] SEG_SELECT_OUT,
  output logic [7:0] HEX_OUT,
  output logic       BUSY_OUT
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  // Active-low segment pattern {G..A} for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [CW-1:0] refresh_cnt_q, refresh_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    disp_val_q, disp_val_d;
  logic [3:0]    seg_sel_q, seg_sel_d;
  logic [7:0]    hex_q, hex_d;
  logic          busy_q, busy_d;

  logic          conv_idle_s;
  logic          capture_s;
  logic [15:0]   dig_val_s;    // nibble per digit, digit n at [4n+3:4n]
  logic [3:0]    dig_blank_s;  // 1 = digit n is dark

`ifdef SEVENSEG_DECIMAL_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } conv_state_t;

  conv_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  hund_q, hund_d;
  logic [11:0] bcd_adj_s;
  logic [19:0] shifted_s;

  // Double-dabble correction: bump every BCD nibble >= 5 by 3 before shifting.
  function automatic logic [11:0] dabble_adjust(input logic [11:0] bcd);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = bcd[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // Converter next state: LOAD once, then eight adjust-and-shift steps.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    bit_cnt_d = bit_cnt_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    hund_d    = hund_q;
    bcd_adj_s = dabble_adjust(bcd_q);
    shifted_s = {bcd_adj_s, shift_q} << 1;
    case (state_q)
      ST_IDLE: begin
        if (capture_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        shift_d   = disp_val_q;
        bcd_d     = 12'h000;
        bit_cnt_d = 3'd0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        bcd_d   = shifted_s[19:8];
        shift_d = shifted_s[7:0];
        if (bit_cnt_q == 3'd7) begin
          ones_d  = shifted_s[11:8];
          tens_d  = shifted_s[15:12];
          hund_d  = shifted_s[19:16];
          state_d = ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Converter registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'h00;
      bcd_q     <= 12'h000;
      bit_cnt_q <= 3'd0;
      ones_q    <= 4'h0;
      tens_q    <= 4'h0;
      hund_q    <= 4'h0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      bit_cnt_q <= bit_cnt_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      hund_q    <= hund_d;
    end
  end

  // Digit contents and leading-zero blanking; ones is always lit.
  always_comb begin
    conv_idle_s = (state_q == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    dig_val_s   = {4'h0, hund_q, tens_q, ones_q};
    dig_blank_s = {1'b1, (hund_q == 4'h0), (hund_q == 4'h0) && (tens_q == 4'h0), 1'b0};
  end
`else
  // Hex mapping: two nibbles on the right, upper digits dark.
  always_comb begin
    conv_idle_s = 1'b1;
    busy_d      = 1'b0;
    dig_val_s   = {8'h00, disp_val_q};
    dig_blank_s = 4'b1100;
  end
`endif

  // Capture, refresh timing and registered output decode.
  always_comb begin
    capture_s  = conv_idle_s && (DATA_IN != disp_val_q);
    disp_val_d = disp_val_q;
    if (capture_s) begin
      disp_val_d = DATA_IN;
    end else begin
      disp_val_d = disp_val_q;
    end

    refresh_cnt_d = refresh_cnt_q;
    idx_d         = idx_q;
    if (refresh_cnt_q == REFRESH_LAST) begin
      refresh_cnt_d = '0;
      idx_d         = idx_q + 2'd1;
    end else begin
      refresh_cnt_d = refresh_cnt_q + CW'(1);
    end

    seg_sel_d = ~(4'b0001 << idx_q);
    if (dig_blank_s[idx_q]) begin
      hex_d = {~DOT_IN[idx_q], 7'h7F};
    end else begin
      hex_d = {~DOT_IN[idx_q], seg_decode(dig_val_s[{idx_q, 2'b00} +: 4])};
    end
  end

  // Display value, refresh state and output registers.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      refresh_cnt_q <= '0;
      idx_q         <= 2'd0;
      disp_val_q    <= 8'h00;
      seg_sel_q     <= 4'hF;
      hex_q         <= 8'hFF;
      busy_q        <= 1'b0;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      disp_val_q    <= disp_val_d;
      seg_sel_q     <= seg_sel_d;
      hex_q         <= hex_d;
      busy_q        <= busy_d;
    end
  end

  assign SEG_SELECT_OUT = seg_sel_q;
  assign HEX_OUT        = hex_q;
  assign BUSY_OUT       = busy_q;

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Self-checking bench for seven_seg_display_driver with REFRESH_DIV = 4.
// The reference model works from the visible behaviour: a cycle count since
// reset release gives the lit digit, and the displayed value is the DATA_IN
// seen one edge earlier (hex mode) or the decimal digits of a settled value.
module tb_seven_seg_display_driver;

  localparam int DIV = 4;

  localparam logic [7:0] SEG_TAB [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic       clk;
  logic       rst_n;
  logic [7:0] data_in;
  logic [3:0] dot_in;
  logic [3:0] seg_sel;
  logic [7:0] hex_out;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  int         k_cyc;      // edges since reset release
  logic [7:0] prev_data;  // DATA_IN at the previous edge

  seven_seg_display_driver #(.REFRESH_DIV(DIV)) dut (
    .CLK            (clk),
    .RESET          (rst_n),
    .DATA_IN        (data_in),
    .DOT_IN         (dot_in),
    .SEG_SELECT_OUT (seg_sel),
    .HEX_OUT        (hex_out),
    .BUSY_OUT       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_hex(input logic [3:0] nib, input logic blank, input logic dot);
    logic [7:0] code;
    code = SEG_TAB[nib];
    return {~dot, blank ? 7'h7F : code[6:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges and check the reset output values.
  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) begin
      tick();
      check_eq("rst_seg", {28'd0, seg_sel}, 32'hF);
      check_eq("rst_hex", {24'd0, hex_out}, 32'hFF);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst_n     = 1'b1;
    k_cyc     = 0;
    prev_data = 8'h00;
  endtask

  // Hex-mode model step: apply inputs, clock once, compare.
  task automatic step_hex(input logic [7:0] d, input logic [3:0] dot);
    int idx;
    logic [7:0] eh;
    data_in = d;
    dot_in  = dot;
    tick();
    k_cyc++;
    idx = ((k_cyc - 1) / DIV) % 4;
    case (idx)
      0:       eh = exp_hex(prev_data[3:0], 1'b0, dot[0]);
      1:       eh = exp_hex(prev_data[7:4], 1'b0, dot[1]);
      default: eh = exp_hex(4'h0, 1'b1, dot[idx]);
    endcase
    check_eq("seg", {28'd0, seg_sel}, {28'd0, ~(4'b0001 << idx)});
    check_eq("hex", {24'd0, hex_out}, {24'd0, eh});
    check_eq("busy0", {31'd0, busy}, 32'd0);
    prev_data = d;
  endtask

  // Decimal-mode scan: whatever digit is lit must show value v's digit.
  task automatic scan_dec(input int v, input int ncyc);
    int idx;
    int ones, tens, hund;
    logic [7:0] eh;
    ones = v % 10;
    tens = (v / 10) % 10;
    hund = v / 100;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      check_eq("dec_onehot", $countones(~seg_sel), 32'd1);
      idx = 0;
      for (int i = 0; i < 4; i++) if (!seg_sel[i]) idx = i;
      case (idx)
        0:       eh = exp_hex(4'(ones), 1'b0, dot_in[0]);
        1:       eh = exp_hex(4'(tens), (hund == 0) && (tens == 0), dot_in[1]);
        2:       eh = exp_hex(4'(hund), hund == 0, dot_in[2]);
        default: eh = exp_hex(4'h0, 1'b1, dot_in[3]);
      endcase
      check_eq($sformatf("dec_hex_v%0d_d%0d", v, idx), {24'd0, hex_out}, {24'd0, eh});
    end
  endtask

  // Count BUSY cycles until it falls, bounded.
  task automatic wait_busy_done(input bit already, output int n);
    bit seen;
    seen = already;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (busy) begin
        n++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    check_eq("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int nb;
    logic [7:0] d;
    logic [3:0] dt;
    rst_n   = 1'b0;
    data_in = 8'h00;
    dot_in  = 4'h0;
    reset_dut();
`ifdef SEVENSEG_DECIMAL_EN
    scan_dec(0, 4 * DIV);
    data_in = 8'd255;
    wait_busy_done(1'b0, nb);
    check_eq("busy_len_255", nb, 32'd9);
    scan_dec(255, 4 * DIV);
    data_in = 8'd7;
    wait_busy_done(1'b0, nb);
    scan_dec(7, 4 * DIV);
    dot_in = 4'b0101;
    data_in = 8'd10;
    tick(); tick(); tick();
    data_in = 8'd99;
    wait_busy_done(1'b1, nb);
    scan_dec(10, 8);
    check_eq("second_conv", {31'd0, busy}, 32'd1);
    wait_busy_done(1'b1, nb);
    scan_dec(99, 4 * DIV);
    dot_in = 4'h0;
    data_in = 8'd200;
    tick(); tick(); tick(); tick();
    check_eq("busy_in_shift", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    data_in = 8'd0;
    tick();
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_seg", {28'd0, seg_sel}, 32'hF);
    check_eq("midrst_hex", {24'd0, hex_out}, 32'hFF);
    rst_n = 1'b1;
    scan_dec(0, 4 * DIV + 2);
    check_eq("idle_after", {31'd0, busy}, 32'd0);
`else
    // Reset frame with zero data: E/C0 x4, D/C0 x4, B/FF x4, 7/FF x4, E/C0.
    for (int i = 0; i < 4 * DIV + 4; i++) step_hex(8'h00, 4'h0);
    for (int i = 0; i < 4 * DIV + 2; i++) step_hex(8'hA7, 4'h0);
    for (int i = 0; i < 4 * DIV + 2; i++) step_hex(8'h00, 4'b0100);
    d  = 8'h00;
    dt = 4'h0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) dt = 4'($urandom);
      if (i == 200) reset_dut();
      step_hex(d, dt);
    end
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
